// File: rtl/uart_to_fifo_stager_pkg.sv
// Shared types for the UART-to-FIFO stager.
// Holds the write FSM state encoding.
package uart_stager_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RDY  = 2'd1,
      TRIGGER   = 2'd2,
      WAIT_DONE = 2'd3
   } UartStager_state;

endpackage

// File: rtl/uart_to_fifo_stager_if.sv
// UART receive / FIFO writer handshake bundle.
// master is the stager side, slave is the environment side.
interface uart_to_fifo_stager_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 3
) ();

   logic              rx_done;
   logic [DATA_W-1:0] rx_data;
   logic              wr_rdy;
   logic              wr_done;
   logic              is_full;
   logic              clr_overflow;
   logic              wr_trigger;
   logic [DATA_W-1:0] wr_data;
   logic [CNT_W-1:0]  stage_count;
   logic              stage_empty;
   logic              overflow;

   modport master (
      input  rx_done, rx_data, wr_rdy, wr_done,
      input  is_full, clr_overflow,
      output wr_trigger, wr_data, stage_count,
      output stage_empty, overflow
   );

   modport slave (
      output rx_done, rx_data, wr_rdy, wr_done,
      output is_full, clr_overflow,
      input  wr_trigger, wr_data, stage_count,
      input  stage_empty, overflow
   );

endinterface

// File: rtl/uart_to_fifo_stager_ring.sv
// Ring buffer between UART receiver and writer FSM.
// A pop frees a slot for a same-cycle push even when full.
import uart_stager_pkg::*;

module uart_stage_ring #(
   parameter int DATA_W      = 8,
   parameter int STAGE_DEPTH = 4,
   localparam int CNT_W      = $clog2(STAGE_DEPTH) + 1,
   localparam int PTR_W      = $clog2(STAGE_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              drop
);

   logic [DATA_W-1:0] r_mem [STAGE_DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_pop;
   logic              w_acc;

   assign full  = (r_count == CNT_W'(STAGE_DEPTH));
   assign empty = (r_count == '0);
   assign w_pop = pop & ~empty;
   assign w_acc = push & (~full | w_pop);
   assign drop  = push & full & ~w_pop;

   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_acc)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_acc, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc)
         r_mem[r_wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_to_fifo_stager.sv
// UART-to-FIFO stager: ring buffer plus Moore write FSM.
// Drains staged words through the writer trigger/ready/done handshake.
import uart_stager_pkg::*;

module uart_to_fifo_stager #(
   parameter int DATA_W      = 8,
   parameter int STAGE_DEPTH = 4
) (
   input logic                  clk,
   input logic                  reset,
   uart_to_fifo_stager_if.master bus
);

   localparam int CNT_W = $clog2(STAGE_DEPTH) + 1;

   UartStager_state   r_state;
   logic              r_trigger;
   logic              r_overflow;
   logic              w_pop;
   logic              w_more;
   logic              w_full;
   logic              w_empty;
   logic              w_drop;
   logic [CNT_W-1:0]  w_count;
   logic [DATA_W-1:0] w_head;

   assign w_pop = (r_state == WAIT_DONE) & bus.wr_done;

   uart_stage_ring #(
      .DATA_W      (DATA_W),
      .STAGE_DEPTH (STAGE_DEPTH)
   ) u_ring (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.rx_done),
      .push_data (bus.rx_data),
      .pop       (w_pop),
      .head_data (w_head),
      .count     (w_count),
      .full      (w_full),
      .empty     (w_empty),
      .drop      (w_drop)
   );

   // A pop always makes room, so any same-cycle push is kept
   assign w_more = (w_count > CNT_W'(1)) | bus.rx_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_trigger <= 1'b0;
      end else begin
         r_trigger <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty)
                  r_state <= WAIT_RDY;
            end
            WAIT_RDY: begin
               if (bus.wr_rdy && !bus.is_full) begin
                  r_state   <= TRIGGER;
                  r_trigger <= 1'b1;
               end
            end
            TRIGGER: begin
               if (!bus.wr_rdy)
                  r_state <= WAIT_DONE;
               else
                  r_trigger <= 1'b1;
            end
            WAIT_DONE: begin
               if (bus.wr_done)
                  r_state <= w_more ? WAIT_RDY : IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_overflow <= 1'b0;
      else if (w_drop)
         r_overflow <= 1'b1;
      else if (bus.clr_overflow)
         r_overflow <= 1'b0;
   end

   assign bus.wr_trigger  = r_trigger;
   assign bus.wr_data     = w_head;
   assign bus.stage_count = w_count;
   assign bus.stage_empty = w_empty;
   assign bus.overflow    = r_overflow;

   logic w_unused;
   assign w_unused = w_full;

endmodule

// File: tb/tb_uart_to_fifo_stager.sv
// Bench for uart_to_fifo_stager: queue model plus directed scenarios.
// Random traffic with a reactive writer closes the run.
module tb_uart_to_fifo_stager;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk;
   logic reset;

   uart_to_fifo_stager_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

   uart_to_fifo_stager #(
      .DATA_W      (DW),
      .STAGE_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: queue of held words, phase 0..3, overflow bit
   logic [DW-1:0] m_q[$];
   int            m_ph  = 0;
   bit            m_ovf = 0;

   always @(posedge clk) begin
      int n0;
      bit pop;
      bit drop;
      if (reset) begin
         m_q.delete();
         m_ph  = 0;
         m_ovf = 0;
      end else begin
         n0   = m_q.size();
         pop  = (m_ph == 3) && bus.wr_done;
         drop = 0;
         if (pop)
            void'(m_q.pop_front());
         if (bus.rx_done) begin
            if (m_q.size() < DEPTH)
               m_q.push_back(bus.rx_data);
            else
               drop = 1;
         end
         if (drop)
            m_ovf = 1;
         else if (bus.clr_overflow)
            m_ovf = 0;
         case (m_ph)
            0: if (n0 != 0) m_ph = 1;
            1: if (bus.wr_rdy && !bus.is_full) m_ph = 2;
            2: if (!bus.wr_rdy) m_ph = 3;
            default: if (bus.wr_done) m_ph = (m_q.size() != 0) ? 1 : 0;
         endcase
      end
   end

   always @(negedge clk) begin
      check("count", 32'(bus.stage_count), 32'(m_q.size()));
      check("empty", 32'(bus.stage_empty), 32'(m_q.size() == 0));
      check("ovf", 32'(bus.overflow), 32'(m_ovf));
      check("trig", 32'(bus.wr_trigger), 32'(m_ph == 2));
      if (m_ph >= 2 && m_q.size() != 0)
         check("head", 32'(bus.wr_data), 32'(m_q[0]));
   end

   // Reactive writer
   bit            auto_wr  = 0;
   bit            wbusy    = 0;
   bit            wrelease = 0;
   int            wcnt     = 0;
   logic [DW-1:0] got[$];

   task automatic writer_step();
      if (wbusy) begin
         wcnt--;
         if (wcnt == 0) begin
            bus.wr_done = 1'b1;
            wbusy       = 0;
            wrelease    = 1;
         end
      end else if (wrelease) begin
         bus.wr_rdy = 1'b1;
         wrelease   = 0;
      end else if (bus.wr_trigger && bus.wr_rdy) begin
         got.push_back(bus.wr_data);
         bus.wr_rdy = 1'b0;
         wbusy      = 1;
         wcnt       = $urandom_range(1, 3);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      bus.rx_done      = 1'b0;
      bus.wr_done      = 1'b0;
      bus.clr_overflow = 1'b0;
      if (auto_wr)
         writer_step();
   endtask

   task automatic push(logic [DW-1:0] d);
      bus.rx_done = 1'b1;
      bus.rx_data = d;
      cyc();
   endtask

   task automatic wait_trig(string nm);
      int k = 0;
      while (!bus.wr_trigger && k < 20) begin
         cyc();
         k++;
      end
      check(nm, 32'(bus.wr_trigger), 32'd1);
   endtask

   task automatic drain(string nm, int n);
      int k = 0;
      while ((got.size() < n || bus.stage_count != 0) && k < 200) begin
         cyc();
         k++;
      end
      check(nm, 32'(got.size()), 32'(n));
      repeat (4) cyc();
   endtask

   logic [DW-1:0] exp_b[3] = '{8'h10, 8'h11, 8'h12};
   logic [DW-1:0] exp_o[4] = '{8'h02, 8'h03, 8'h04, 8'h06};

   initial begin
      reset            = 1'b1;
      bus.rx_done      = 1'b0;
      bus.rx_data      = '0;
      bus.wr_rdy       = 1'b1;
      bus.wr_done      = 1'b0;
      bus.is_full      = 1'b0;
      bus.clr_overflow = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      check("rst_count", 32'(bus.stage_count), 32'd0);
      check("rst_empty", 32'(bus.stage_empty), 32'd1);
      check("rst_trig", 32'(bus.wr_trigger), 32'd0);
      check("rst_ovf", 32'(bus.overflow), 32'd0);

      // Single word latency
      push(8'h41);
      check("lat_c1_count", 32'(bus.stage_count), 32'd1);
      check("lat_c1_trig", 32'(bus.wr_trigger), 32'd0);
      cyc();
      check("lat_c2_trig", 32'(bus.wr_trigger), 32'd0);
      cyc();
      check("lat_c3_trig", 32'(bus.wr_trigger), 32'd1);
      check("lat_c3_data", 32'(bus.wr_data), 32'h41);
      bus.wr_rdy = 1'b0;
      cyc();
      bus.wr_done = 1'b1;
      cyc();
      check("single_count", 32'(bus.stage_count), 32'd0);
      check("single_empty", 32'(bus.stage_empty), 32'd1);
      bus.wr_rdy = 1'b1;
      repeat (2) cyc();

      // Burst while downstream FIFO is full
      bus.is_full = 1'b1;
      push(8'h10);
      push(8'h11);
      push(8'h12);
      repeat (3) cyc();
      check("burst_count", 32'(bus.stage_count), 32'd3);
      check("burst_trig", 32'(bus.wr_trigger), 32'd0);
      got.delete();
      auto_wr     = 1;
      bus.is_full = 1'b0;
      drain("burst_n", 3);
      for (int i = 0; i < 3; i++)
         if (i < got.size())
            check("burst_order", 32'(got[i]), 32'(exp_b[i]));
      auto_wr = 0;

      // Overflow, set/clear collision, push+pop at full
      bus.is_full = 1'b1;
      for (int i = 1; i <= 5; i++)
         push(DW'(i));
      cyc();
      check("ovf_count", 32'(bus.stage_count), 32'd4);
      check("ovf_set", 32'(bus.overflow), 32'd1);
      bus.clr_overflow = 1'b1;
      push(8'h66);
      check("ovf_collide", 32'(bus.overflow), 32'd1);
      check("ovf_keep4", 32'(bus.stage_count), 32'd4);
      bus.clr_overflow = 1'b1;
      cyc();
      check("ovf_clr", 32'(bus.overflow), 32'd0);
      bus.is_full = 1'b0;
      wait_trig("ovf_trig_to");
      check("ovf_head", 32'(bus.wr_data), 32'h01);
      bus.wr_rdy = 1'b0;
      cyc();
      bus.wr_done = 1'b1;
      push(8'h06);
      check("pp_count", 32'(bus.stage_count), 32'd4);
      check("pp_ovf", 32'(bus.overflow), 32'd0);
      bus.wr_rdy = 1'b1;
      got.delete();
      auto_wr = 1;
      drain("ovf_n", 4);
      for (int i = 0; i < 4; i++)
         if (i < got.size())
            check("ovf_order", 32'(got[i]), 32'(exp_o[i]));
      auto_wr = 0;

      // Reset during TRIGGER with three words held
      bus.is_full = 1'b1;
      push(8'h21);
      push(8'h22);
      push(8'h23);
      bus.is_full = 1'b0;
      wait_trig("rstw_trig_to");
      check("rstw_count", 32'(bus.stage_count), 32'd3);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("rstw_trig", 32'(bus.wr_trigger), 32'd0);
      check("rstw_count0", 32'(bus.stage_count), 32'd0);
      check("rstw_empty", 32'(bus.stage_empty), 32'd1);
      bus.wr_done = 1'b1;
      cyc();
      check("stray_count", 32'(bus.stage_count), 32'd0);
      check("stray_trig", 32'(bus.wr_trigger), 32'd0);

      // Random traffic
      auto_wr = 1;
      for (int i = 0; i < 4000; i++) begin
         reset            = ($urandom_range(0, 399) == 0);
         bus.rx_done      = ($urandom_range(0, 2) == 0);
         bus.rx_data      = DW'($urandom);
         bus.is_full      = ($urandom_range(0, 3) == 0);
         bus.clr_overflow = ($urandom_range(0, 15) == 0);
         if (!wbusy && !wrelease && !bus.wr_trigger &&
             $urandom_range(0, 19) == 0)
            bus.wr_done = 1'b1;
         cyc();
      end
      reset       = 1'b0;
      bus.is_full = 1'b0;
      repeat (40) cyc();
      check("final_empty", 32'(bus.stage_empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
